// File: rtl/sdram_refresh_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_refresh_scheduler
//  Description : Generates SDRAM refresh requests for a CLK80-domain memory
//                controller. An interval counter ticks once every INTERVAL
//                CLK7 cycles. Each tick adds one owed refresh ("debt"). Each
//                completed four-phase REQ/ACK handshake pays one back and
//                advances the round-robin rank pointer.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK7        in   1       sole clock, rising edge
//    REF_RESET   in   1       asynchronous active-high reset
//    EN          in   1       scheduling enable (SDRAM configured)
//    REF_ACK     in   1       acknowledge from controller, asynchronous
//    REF_REQ     out  1       registered refresh request level
//    REF_URGENT  out  1       registered, debt at or above URGENT_LEVEL
//    REF_RANK    out  RANK_W  rank to refresh, stable while REF_REQ=1
//    DEBT        out  DEBT_W  owed refreshes
//    OVERFLOW    out  1       sticky, a tick was lost at saturated debt
// ============================================================================
module sdram_refresh_scheduler #(
    parameter int INTERVAL     = 54,
    parameter int CNT_W        = 6,
    parameter int MAX_DEBT     = 8,
    parameter int DEBT_W       = 4,
    parameter int URGENT_LEVEL = 6,
    parameter int NUM_RANKS    = 2,
    parameter int RANK_W       = 1
) (
    input  logic              CLK7,
    input  logic              REF_RESET,
    input  logic              EN,
    input  logic              REF_ACK,
    output logic              REF_REQ,
    output logic              REF_URGENT,
    output logic [RANK_W-1:0] REF_RANK,
    output logic [DEBT_W-1:0] DEBT,
    output logic              OVERFLOW
);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(INTERVAL - 1);
    localparam logic [DEBT_W-1:0] DEBT_MAX   = DEBT_W'(MAX_DEBT);
    localparam logic [DEBT_W-1:0] URGENT_THR = DEBT_W'(URGENT_LEVEL);
    localparam logic [RANK_W-1:0] RANK_LAST  = RANK_W'(NUM_RANKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ACKWAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              ack_meta;
    logic              ack_s;
    logic [CNT_W-1:0]  cnt;
    logic              tick;
    logic              complete;
    logic [DEBT_W-1:0] debt_next;
    logic              ovf_set;

    // Two-flop synchronizer for the CLK80-domain acknowledge.
    always_ff @(posedge CLK7 or posedge REF_RESET) begin
        if (REF_RESET) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= REF_ACK;
            ack_s    <= ack_meta;
        end
    end

    // Interval counter; held at zero while disabled so that enabling always
    // starts a full interval.
    always_ff @(posedge CLK7 or posedge REF_RESET) begin
        if (REF_RESET) begin
            cnt <= '0;
        end else if (!EN || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = EN && (cnt == CNT_LAST);

    // Handshake FSM. Dropping EN in REQ abandons the request (no completion);
    // once the acknowledge has been seen the handshake always runs to the end
    // so the controller is never left with a dangling ACK.
    always_comb begin
        state_next = state;
        complete   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (EN && (DEBT != '0)) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!EN) begin
                    state_next = ST_IDLE;
                end else if (ack_s) begin
                    state_next = ST_ACKWAIT;
                    complete   = 1'b1;
                end
            end
            ST_ACKWAIT: begin
                if (!ack_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Debt bookkeeping. A simultaneous tick and completion cancel out, which
    // also means a tick at full debt is not lost in that case.
    always_comb begin
        debt_next = DEBT;
        ovf_set   = 1'b0;
        case ({tick, complete})
            2'b10: begin
                if (DEBT >= DEBT_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    debt_next = DEBT + 1'b1;
                end
            end
            2'b01: begin
                if (DEBT != '0) begin
                    debt_next = DEBT - 1'b1;
                end
            end
            default: begin
                debt_next = DEBT;
            end
        endcase
    end

    always_ff @(posedge CLK7 or posedge REF_RESET) begin
        if (REF_RESET) begin
            state      <= ST_IDLE;
            REF_REQ    <= 1'b0;
            REF_URGENT <= 1'b0;
            REF_RANK   <= '0;
            DEBT       <= '0;
            OVERFLOW   <= 1'b0;
        end else begin
            state      <= state_next;
            REF_REQ    <= (state_next == ST_REQ);
            REF_URGENT <= (debt_next >= URGENT_THR);
            DEBT       <= debt_next;
            OVERFLOW   <= OVERFLOW | ovf_set;
            // Rank only moves on completion, so it is stable throughout REQ.
            if (complete) begin
                REF_RANK <= (REF_RANK == RANK_LAST) ? '0 : REF_RANK + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_refresh_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_refresh_scheduler
//  Description : Directed self-checking bench for sdram_refresh_scheduler.
//                Expected values are queued when a step is set up and popped
//                at the sampling point (1 ns after the clock edge). A bench
//                cycle counter, restarted by reset, times the steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_refresh_scheduler;

    logic       CLK7 = 1'b0;
    logic       REF_RESET;
    logic       EN;
    logic       REF_ACK;
    logic       REF_REQ;
    logic       REF_URGENT;
    logic [0:0] REF_RANK;
    logic [3:0] DEBT;
    logic       OVERFLOW;

    logic       en2;
    logic       ack2;
    logic       req2;
    logic       urg2;
    logic [1:0] rank2;
    logic [3:0] debt2;
    logic       ovf2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    sdram_refresh_scheduler dut (
        .CLK7       (CLK7),
        .REF_RESET  (REF_RESET),
        .EN         (EN),
        .REF_ACK    (REF_ACK),
        .REF_REQ    (REF_REQ),
        .REF_URGENT (REF_URGENT),
        .REF_RANK   (REF_RANK),
        .DEBT       (DEBT),
        .OVERFLOW   (OVERFLOW)
    );

    sdram_refresh_scheduler #(
        .INTERVAL  (10),
        .NUM_RANKS (3),
        .RANK_W    (2)
    ) dut3 (
        .CLK7       (CLK7),
        .REF_RESET  (REF_RESET),
        .EN         (en2),
        .REF_ACK    (ack2),
        .REF_REQ    (req2),
        .REF_URGENT (urg2),
        .REF_RANK   (rank2),
        .DEBT       (debt2),
        .OVERFLOW   (ovf2)
    );

    always #5 CLK7 = ~CLK7;

    // Edges since the last reset release.
    always @(posedge CLK7 or posedge REF_RESET) begin
        if (REF_RESET) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_empty observed=%0h expected=queued_value", obs);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance to 1 ns after edge number n (n must be ahead of cyc).
    task automatic to_cyc(input int n);
        do begin
            @(posedge CLK7);
            #1;
        end while (cyc < n);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK7);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge CLK7);
        #1 REF_RESET = 1'b1;
        @(posedge CLK7);
        #1 REF_RESET = 1'b0;
    endtask

    // Bounded wait for a request level on instance 1 or 2.
    task automatic wait_req(input int which, input logic lvl, input int budget,
                            input string tag);
        int   k = 0;
        logic s;
        s = (which == 1) ? REF_REQ : req2;
        while ((s !== lvl) && (k < budget)) begin
            @(posedge CLK7);
            #1;
            k++;
            s = (which == 1) ? REF_REQ : req2;
        end
        n_tests++;
        assert (s === lvl) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, s, lvl);
        end
    endtask

    initial begin
        REF_RESET = 1'b1;
        EN        = 1'b1;
        REF_ACK   = 1'b0;
        en2       = 1'b0;
        ack2      = 1'b0;

        // ---- reset state and first tick --------------------------------
        do_reset();
        sb_push("rst_req", 0);  sb_push("rst_urg", 0);  sb_push("rst_rank", 0);
        sb_push("rst_debt", 0); sb_push("rst_ovf", 0);
        sb_check(REF_REQ); sb_check(REF_URGENT); sb_check(REF_RANK);
        sb_check(DEBT);    sb_check(OVERFLOW);

        sb_push("c53_debt", 0); sb_push("c53_req", 0);
        to_cyc(53);
        sb_check(DEBT); sb_check(REF_REQ);
        sb_push("c54_debt", 1); sb_push("c54_req", 0);
        to_cyc(54);
        sb_check(DEBT); sb_check(REF_REQ);
        sb_push("c55_req", 1); sb_push("c55_debt", 1);
        to_cyc(55);
        sb_check(REF_REQ); sb_check(DEBT);

        // ---- steady handshakes: debt 0/1, rank 0,1,0 -------------------
        for (int i = 0; i < 3; i++) begin
            wait_req(1, 1'b1, 120, "hs_req_rise");
            sb_push("hs_rank", (i == 1) ? 1 : 0);
            sb_push("hs_debt_req", 1);
            sb_check(REF_RANK); sb_check(DEBT);
            step(2);
            REF_ACK = 1'b1;
            wait_req(1, 1'b0, 10, "hs_req_fall");
            REF_ACK = 1'b0;
            sb_push("hs_debt_done", 0);
            sb_check(DEBT);
        end

        // ---- no acknowledge: urgency, saturation, overflow -------------
        do_reset();
        sb_push("c323_debt", 5); sb_push("c323_urg", 0);
        to_cyc(323);
        sb_check(DEBT); sb_check(REF_URGENT);
        sb_push("c324_debt", 6); sb_push("c324_urg", 1); sb_push("c324_req", 1);
        to_cyc(324);
        sb_check(DEBT); sb_check(REF_URGENT); sb_check(REF_REQ);
        sb_push("c431_debt", 7);
        to_cyc(431);
        sb_check(DEBT);
        sb_push("c432_debt", 8); sb_push("c432_ovf", 0);
        to_cyc(432);
        sb_check(DEBT); sb_check(OVERFLOW);
        sb_push("c485_ovf", 0);
        to_cyc(485);
        sb_check(OVERFLOW);
        sb_push("c486_ovf", 1); sb_push("c486_debt", 8); sb_push("c486_urg", 1);
        to_cyc(486);
        sb_check(OVERFLOW); sb_check(DEBT); sb_check(REF_URGENT);
        sb_push("c600_ovf_sticky", 1);
        to_cyc(600);
        sb_check(OVERFLOW);

        // ---- completion coinciding with a tick at debt 3 ---------------
        do_reset();
        to_cyc(213);
        REF_ACK = 1'b1;
        sb_push("c215_debt", 3); sb_push("c215_req", 1);
        to_cyc(215);
        sb_check(DEBT); sb_check(REF_REQ);
        sb_push("coinc_debt", 3); sb_push("coinc_ovf", 0); sb_push("coinc_req", 0);
        sb_push("coinc_rank", 1); sb_push("coinc_urg", 0);
        to_cyc(216);
        sb_check(DEBT); sb_check(OVERFLOW); sb_check(REF_REQ);
        sb_check(REF_RANK); sb_check(REF_URGENT);
        REF_ACK = 1'b0;

        // ---- EN dropped during REQ, then held low ----------------------
        sb_push("c220_req", 1);
        to_cyc(220);
        sb_check(REF_REQ);
        to_cyc(221);
        EN = 1'b0;
        sb_push("en0_req", 0); sb_push("en0_debt", 3); sb_push("en0_rank", 1);
        to_cyc(222);
        sb_check(REF_REQ); sb_check(DEBT); sb_check(REF_RANK);
        sb_push("en0_hold_debt", 3); sb_push("en0_hold_req", 0);
        to_cyc(330);
        sb_check(DEBT); sb_check(REF_REQ);
        EN = 1'b1;
        sb_push("en1_req", 1);
        to_cyc(331);
        sb_check(REF_REQ);
        sb_push("en1_c383_debt", 3);
        to_cyc(383);
        sb_check(DEBT);
        sb_push("en1_c384_debt", 4);
        to_cyc(384);
        sb_check(DEBT);

        // ---- reset mid-handshake, stale ACK held high ------------------
        do_reset();
        sb_push("r_c55_req", 1);
        to_cyc(55);
        sb_check(REF_REQ);
        REF_ACK = 1'b1;
        sb_push("r_c56_req", 1);
        to_cyc(56);
        sb_check(REF_REQ);
        REF_RESET = 1'b1;
        #1;
        sb_push("arst_req", 0);  sb_push("arst_urg", 0); sb_push("arst_rank", 0);
        sb_push("arst_debt", 0); sb_push("arst_ovf", 0);
        sb_check(REF_REQ); sb_check(REF_URGENT); sb_check(REF_RANK);
        sb_check(DEBT);    sb_check(OVERFLOW);
        #1 REF_RESET = 1'b0;
        sb_push("stale_c53_req", 0); sb_push("stale_c53_debt", 0);
        to_cyc(53);
        sb_check(REF_REQ); sb_check(DEBT);
        sb_push("stale_c54_debt", 1); sb_push("stale_c54_req", 0);
        to_cyc(54);
        sb_check(DEBT); sb_check(REF_REQ);
        sb_push("stale_c55_req", 1);
        to_cyc(55);
        sb_check(REF_REQ);
        sb_push("stale_c56_req", 0); sb_push("stale_c56_debt", 0);
        sb_push("stale_c56_rank", 1);
        to_cyc(56);
        sb_check(REF_REQ); sb_check(DEBT); sb_check(REF_RANK);
        REF_ACK = 1'b0;

        // ---- three ranks, interval 10 ----------------------------------
        do_reset();
        EN  = 1'b0;
        en2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_req(2, 1'b1, 40, "r3_req_rise");
            sb_push("r3_rank", (i == 3) ? 0 : i);
            sb_check(rank2);
            step(2);
            ack2 = 1'b1;
            wait_req(2, 1'b0, 10, "r3_req_fall");
            ack2 = 1'b0;
        end
        sb_push("r3_ovf", 0);
        sb_check(ovf2);

        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
